// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor recovering a = y - b LSB-first, one bit per clock.
// Rev 1.0 - start/busy/done framed, with underflow (neg) and does-not-fit (ovf) flags.
`default_nettype none

module serial_sub #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] y,
  input  logic [W-2:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-2:0] a,
  output logic         neg,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  ym_q;
  logic [W-1:0]  bm_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_d;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          br_d;
  logic          diff_d;

  always_comb begin
    diff_d = ym_q[0] ^ bm_q[0] ^ br_q;
    br_d   = (~ym_q[0] & bm_q[0]) | (~(ym_q[0] ^ bm_q[0]) & br_q);
    res_d  = {diff_d, res_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ym_q    <= '0;
      bm_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a       <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          if (start) begin
            ym_q    <= y;
            bm_q    <= {1'b0, b};
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy    <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          res_q <= res_d;
          br_q  <= br_d;
          ym_q  <= {1'b0, ym_q[W-1:1]};
          bm_q  <= {1'b0, bm_q[W-1:1]};
          cnt_q <= cnt_q + CW'(1);
          // The edge that consumes the MSB publishes the result directly.
          if (cnt_q == C_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            a       <= res_d[W-2:0];
            neg     <= br_d;
            ovf     <= res_d[W-1] & ~br_d;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and model-checked stimulus for serial_sub at W=3 and W=8.
`default_nettype none

module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start3, start8;
  logic [2:0] y3;
  logic [1:0] b3;
  logic [7:0] y8;
  logic [6:0] b8;
  logic       busy3, done3, neg3, ovf3;
  logic [1:0] a3;
  logic       busy8, done8, neg8, ovf8;
  logic [6:0] a8;

  int checks   = 0;
  int failures = 0;

  serial_sub #(.W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .y(y3), .b(b3),
    .busy(busy3), .done(done3), .a(a3), .neg(neg3), .ovf(ovf3)
  );

  serial_sub #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .y(y8), .b(b8),
    .busy(busy8), .done(done8), .a(a8), .neg(neg8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op3(input logic [2:0] yv, input logic [1:0] bv, input logic [1:0] ea,
                     input logic en, input logic eo, input string tag);
    int lat;
    start3 = 1'b1; y3 = yv; b3 = bv;
    tick();
    start3 = 1'b0; y3 = ~yv; b3 = ~bv;
    chk({tag, "_busy"}, {31'd0, busy3}, 32'd1);
    lat = 0;
    while (done3 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd3);
    chk({tag, "_a"}, {30'd0, a3}, {30'd0, ea});
    chk({tag, "_flags"}, {30'd0, neg3, ovf3}, {30'd0, en, eo});
  endtask

  task automatic op8(input logic [7:0] yv, input logic [6:0] bv, input string tag);
    int lat;
    logic [7:0] d;
    logic       n;
    logic       o;
    d = yv - {1'b0, bv};
    n = (yv < {1'b0, bv});
    o = !n && d[7];
    start8 = 1'b1; y8 = yv; b8 = bv;
    tick();
    start8 = 1'b0; y8 = ~yv;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd8);
    chk({tag, "_res"}, {24'd0, ovf8 | neg8, a8}, {24'd0, o | n, d[6:0]});
    chk({tag, "_neg"}, {31'd0, neg8}, {31'd0, n});
  endtask

  initial begin
    int n;
    int lat;
    logic [2:0] d3;
    logic       n3;
    logic       o3;

    rst_n = 1'b0; start3 = 1'b0; start8 = 1'b0;
    y3 = '0; b3 = '0; y8 = '0; b8 = '0;
    tick(); tick();
    chk("rst_outs3", {27'd0, busy3, done3, a3, neg3, ovf3}, 32'd0);
    chk("rst_outs8", {21'd0, busy8, done8, a8, neg8, ovf8}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-computed results.
    op3(3'd6, 2'd3, 2'd3, 1'b0, 1'b0, "basic");
    tick();
    chk("done_pulse", {31'd0, done3}, 32'd0);
    chk("a_hold", {30'd0, a3}, 32'd3);
    op3(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, "zero");
    op3(3'd5, 2'd2, 2'd3, 1'b0, 1'b0, "y5b2");
    op3(3'd1, 2'd2, 2'd3, 1'b1, 1'b0, "under");
    op3(3'd7, 2'd0, 2'd3, 1'b0, 1'b1, "over");
    tick(); tick();

    // start pulsed during SHIFT must be ignored
    start3 = 1'b1; y3 = 3'd6; b3 = 2'd3;
    tick();
    start3 = 1'b0;
    tick();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    repeat (8) begin
      if (done3 === 1'b1) n++;
      tick();
    end
    chk("ignore_start_dones", n, 32'd1);

    // start held high straight through DONE
    start3 = 1'b1; y3 = 3'd6; b3 = 2'd3;
    tick();
    lat = 0;
    while (done3 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    y3 = 3'd4; b3 = 2'd1;
    chk("b2b_first_a", {30'd0, a3}, 32'd3);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done3 !== 1'b1 && lat < 20);
    chk("b2b_period", lat, 32'd4);
    chk("b2b_second_a", {29'd0, a3, neg3}, {29'd0, 2'd3, 1'b0});
    start3 = 1'b0;
    tick(); tick();

    // reset two cycles into an operation, then reset coinciding with start
    start3 = 1'b1; y3 = 3'd5; b3 = 2'd1;
    tick();
    start3 = 1'b0;
    tick();
    rst_n = 1'b0; start3 = 1'b1;
    tick();
    chk("midrst_outs", {27'd0, busy3, done3, a3, neg3, ovf3}, 32'd0);
    tick();
    chk("rst_start_busy", {31'd0, busy3}, 32'd0);
    rst_n = 1'b1; start3 = 1'b0;
    n = 0;
    repeat (6) begin
      if (done3 === 1'b1) n++;
      tick();
    end
    chk("midrst_no_done", n, 32'd0);
    op3(3'd3, 2'd1, 2'd2, 1'b0, 1'b0, "after_rst");

    // Exhaustive W=3 against an integer reference model.
    for (int yi = 0; yi < 8; yi++) begin
      for (int bi = 0; bi < 4; bi++) begin
        d3 = 3'(yi - bi);
        n3 = (yi < bi);
        o3 = !n3 && d3[2];
        op3(3'(yi), 2'(bi), d3[1:0], n3, o3, "sweep3");
      end
    end

    // W=8 boundaries and random pairs.
    op8(8'd0, 7'd127, "w8_min");
    op8(8'd255, 7'd0, "w8_max");
    op8(8'd127, 7'd127, "w8_eq");
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), "w8_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
